// File: rtl/mil1553_pkg.sv
// Shared types, frame constants and encoding helpers for the MIL-STD-1553
// transmit path.
package mil1553_pkg;

    typedef enum logic {
        SYNC_DATA    = 1'b0,
        SYNC_CMD_STS = 1'b1
    } sync_type_e;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA,
        PARITY
    } tx_state_e;

    localparam int WORD_BITS       = 16;
    localparam int SYNC_HALF_BITS  = 6;
    localparam int WORD_HALF_BITS  = 40;
    localparam int PARITY_HALF_IDX = SYNC_HALF_BITS + 2 * WORD_BITS;

    // Sync waveforms, bit 5 is the first half bit on the line (1 = line high).
    localparam logic [5:0] SYNC_PATTERN_CMD_STS = 6'b111000;
    localparam logic [5:0] SYNC_PATTERN_DATA    = 6'b000111;

    // Parity bit that makes the total count of ones (word + parity) odd.
    function automatic logic odd_parity(input logic [WORD_BITS-1:0] word);
        return ~^word;
    endfunction

    // Line level (1 = high) for half bit idx of a frame carrying word.
    function automatic logic half_bit_level(input logic [5:0]           idx,
                                            input logic [WORD_BITS-1:0] word,
                                            input sync_type_e           st);
        logic [5:0] pattern;
        logic [5:0] data_idx;
        logic       bit_val;
        logic       level;
        pattern  = (st == SYNC_CMD_STS) ? SYNC_PATTERN_CMD_STS : SYNC_PATTERN_DATA;
        data_idx = idx - 6'(SYNC_HALF_BITS);
        bit_val  = 1'b0;
        level    = 1'b0;
        if (idx < 6'(SYNC_HALF_BITS)) begin
            level = pattern[3'd5 - idx[2:0]];
        end else if (idx < 6'(PARITY_HALF_IDX)) begin
            // Two half bits per data bit, MSB first; first half carries the bit value.
            bit_val = word[4'd15 - data_idx[4:1]];
            level   = data_idx[0] ? ~bit_val : bit_val;
        end else begin
            bit_val = odd_parity(word);
            level   = idx[0] ? ~bit_val : bit_val;
        end
        return level;
    endfunction

endpackage

// File: rtl/half_bit_timer.sv
// Free-running half-bit clock counter; o_tick marks the last clock of each
// half bit. Reused by the bus-timeout and response-gap timers.
module half_bit_timer #(
    parameter int HALF_BIT_CLKS = 25,
    parameter int TIMER_SIZE    = $clog2(HALF_BIT_CLKS)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_tick
);

    if (HALF_BIT_CLKS < 2) begin : g_bad_half_bit
        $fatal(1, "HALF_BIT_CLKS must be >= 2");
    end
    if (TIMER_SIZE < 1 || (HALF_BIT_CLKS - 1) >= (2 ** TIMER_SIZE)) begin : g_bad_width
        $fatal(1, "TIMER_SIZE too small for HALF_BIT_CLKS");
    end

    logic [TIMER_SIZE-1:0] cnt;

    assign o_tick = (cnt == TIMER_SIZE'(HALF_BIT_CLKS - 1));

    // Count 0..HALF_BIT_CLKS-1 and wrap; clear holds the count at the start of a half bit.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every flop samples values from before the edge.
        if (i_rst || i_clear) begin
            cnt <= '0;
        end else if (o_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mil1553_manchester_encoder.sv
// Manchester II bi-phase transmit encoder: sync, 16 data bits MSB first and
// odd parity per word, with gapless chaining of back-to-back words.
module mil1553_manchester_encoder
    import mil1553_pkg::*;
#(
    parameter int HALF_BIT_CLKS = 25,
    parameter int TIMER_SIZE    = $clog2(HALF_BIT_CLKS)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_data,
    input  logic        i_sync_type,
    input  logic        i_tx_inhibit,
    output logic        o_tx_pos,
    output logic        o_tx_neg,
    output logic        o_tx_en,
    output logic        o_busy,
    output logic        o_done
);

    if (HALF_BIT_CLKS < 2) begin : g_bad_half_bit
        $fatal(1, "HALF_BIT_CLKS must be >= 2");
    end
    if (TIMER_SIZE < 1 || (HALF_BIT_CLKS - 1) >= (2 ** TIMER_SIZE)) begin : g_bad_width
        $fatal(1, "TIMER_SIZE too small for HALF_BIT_CLKS");
    end

    tx_state_e            state;
    logic [5:0]           half_idx;
    logic [5:0]           next_idx;
    logic [WORD_BITS-1:0] word_q;
    sync_type_e           sync_q;
    logic                 tick;
    logic                 last_clk;
    logic                 accept;
    logic                 timer_clear;

    // The timer is held at zero while idle so the first half bit of a word is full length.
    assign timer_clear = (state == IDLE) || accept || i_tx_inhibit;

    half_bit_timer #(
        .HALF_BIT_CLKS (HALF_BIT_CLKS),
        .TIMER_SIZE    (TIMER_SIZE)
    ) u_half_bit_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (timer_clear),
        .o_tick  (tick)
    );

    assign next_idx = half_idx + 6'd1;
    assign last_clk = (state == PARITY) && tick && (half_idx == 6'(WORD_HALF_BITS - 1));
    assign o_ready  = ~i_tx_inhibit && ((state == IDLE) || last_clk);
    assign accept   = i_valid && o_ready;
    assign o_done   = last_clk;

    // Frame sequencer: latches a word on accept and steps the line one half bit per tick.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_tx_inhibit) begin
            state    <= IDLE;
            half_idx <= '0;
            word_q   <= '0;
            sync_q   <= SYNC_DATA;
            o_tx_pos <= 1'b0;
            o_tx_neg <= 1'b0;
            o_tx_en  <= 1'b0;
            o_busy   <= 1'b0;
        end else if (accept) begin
            state    <= SYNC;
            half_idx <= '0;
            word_q   <= i_data;
            sync_q   <= sync_type_e'(i_sync_type);
            o_tx_pos <= half_bit_level(6'd0, i_data, sync_type_e'(i_sync_type));
            o_tx_neg <= ~half_bit_level(6'd0, i_data, sync_type_e'(i_sync_type));
            o_tx_en  <= 1'b1;
            o_busy   <= 1'b1;
        end else if (tick && (state != IDLE)) begin
            if (half_idx == 6'(WORD_HALF_BITS - 1)) begin
                state    <= IDLE;
                half_idx <= '0;
                o_tx_pos <= 1'b0;
                o_tx_neg <= 1'b0;
                o_tx_en  <= 1'b0;
                o_busy   <= 1'b0;
            end else begin
                half_idx <= next_idx;
                o_tx_pos <= half_bit_level(next_idx, word_q, sync_q);
                o_tx_neg <= ~half_bit_level(next_idx, word_q, sync_q);
                case (state)
                    SYNC:    if (next_idx == 6'(SYNC_HALF_BITS)) state <= DATA;
                    DATA:    if (next_idx == 6'(PARITY_HALF_IDX)) state <= PARITY;
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mil1553_manchester_encoder.sv
// Self-checking bench: directed scenarios plus random traffic compared
// cycle by cycle against a queue-based waveform model of the frame.
module tb_mil1553_manchester_encoder;

    localparam int HB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [15:0] data;
    logic        sync_type;
    logic        inhibit;
    logic        tx_pos;
    logic        tx_neg;
    logic        tx_en;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int en_cnt   = 0;
    bit checking = 0;

    // Expected line level for each future cycle of the word in flight.
    bit exp_q[$];

    always #5 clk = ~clk;

    mil1553_manchester_encoder #(.HALF_BIT_CLKS(HB)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (valid),
        .o_ready      (ready),
        .i_data       (data),
        .i_sync_type  (sync_type),
        .i_tx_inhibit (inhibit),
        .o_tx_pos     (tx_pos),
        .o_tx_neg     (tx_neg),
        .o_tx_en      (tx_en),
        .o_busy       (busy),
        .o_done       (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Frame built from the line-coding rules: sync, 16 bits MSB first, odd parity.
    task automatic push_word(input logic [15:0] d, input logic st);
        bit lvl;
        bit b;
        for (int h = 0; h < 40; h++) begin
            if (h < 6) begin
                lvl = st ? (h < 3) : (h >= 3);
            end else begin
                if (h < 38) b = d[15 - (h - 6) / 2];
                else        b = ($countones(d) % 2 == 0);
                lvl = (h % 2 == 0) ? b : !b;
            end
            for (int c = 0; c < HB; c++) exp_q.push_back(lvl);
        end
    endtask

    // One clock: drive inputs, compare outputs against the model, then advance the model.
    task automatic step(input logic r, input logic v, input logic [15:0] d,
                        input logic st, input logic inh);
        bit mready;
        bit has;
        @(negedge clk);
        rst = r; valid = v; data = d; sync_type = st; inhibit = inh;
        #1;
        has    = (exp_q.size() > 0);
        mready = !inh && (exp_q.size() <= 1);
        if (checking) begin
            check("pos",   tx_pos, has ? exp_q[0] : 1'b0);
            check("neg",   tx_neg, has ? !exp_q[0] : 1'b0);
            check("tx_en", tx_en,  has);
            check("busy",  busy,   has);
            check("done",  done,   exp_q.size() == 1);
            check("no_both_hi", tx_pos & tx_neg, 1'b0);
            if (!r) check("ready", ready, mready);
            if (done === 1'b1) done_cnt++;
            if (tx_en === 1'b1) en_cnt++;
        end
        @(posedge clk);
        checking = 1;
        if (r || inh) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (v && mready) push_word(d, st);
        end
    endtask

    task automatic idle_until_empty();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 400) begin
            step(0, 0, 16'h0, 0, 0);
            guard++;
        end
        if (guard >= 400) check("timeout_empty", 1, 0);
        step(0, 0, 16'h0, 0, 0);
    endtask

    initial begin
        int d0;
        int e0;
        int guard;
        int inh_left;
        logic [15:0] rd;
        logic r_rst;
        logic r_inh;
        rst = 1; valid = 0; data = '0; sync_type = 0; inhibit = 0;

        // Reset held for three cycles, then released.
        repeat (3) step(1, 0, 16'h0, 0, 0);
        step(0, 0, 16'h0, 0, 0);

        // Command sync, 0xA5A5: exactly 160 enabled cycles and one done pulse.
        d0 = done_cnt; e0 = en_cnt;
        step(0, 1, 16'hA5A5, 1, 0);
        idle_until_empty();
        check("a5a5_done_cnt", done_cnt - d0, 1);
        check("a5a5_len", en_cnt - e0, 160);

        // Two data words chained with no gap; second offered on the final clock.
        d0 = done_cnt; e0 = en_cnt;
        step(0, 1, 16'h0000, 0, 0);
        guard = 0;
        while (exp_q.size() != 1 && guard < 400) begin
            step(0, 0, 16'hFFFF, 1, 0);
            guard++;
        end
        if (guard >= 400) check("timeout_chain", 1, 0);
        step(0, 1, 16'h0001, 0, 0);
        idle_until_empty();
        check("chain_done_cnt", done_cnt - d0, 2);
        check("chain_len", en_cnt - e0, 320);

        // Inhibit at cycle 50 of a word, valid held high throughout.
        d0 = done_cnt;
        step(0, 1, 16'h1234, 1, 0);
        repeat (49) step(0, 1, 16'h5555, 0, 0);
        repeat (5) step(0, 1, 16'h5555, 0, 1);
        check("inhibit_no_done", done_cnt - d0, 0);
        step(0, 0, 16'h0, 0, 0);

        // Reset mid-DATA together with valid: word is dropped and nothing accepted.
        step(0, 1, 16'hBEEF, 0, 0);
        repeat (60) step(0, 1, $urandom, $urandom, 0);
        step(1, 1, 16'hCAFE, 1, 0);
        step(0, 0, 16'h0, 0, 0);
        step(0, 0, 16'h0, 0, 0);

        // Random traffic: valid mostly high, data changing every cycle, occasional aborts.
        inh_left = 0;
        for (int i = 0; i < 5000; i++) begin
            rd    = 16'($urandom);
            r_rst = ($urandom_range(0, 1499) == 0);
            if (inh_left > 0) inh_left--;
            else if ($urandom_range(0, 499) == 0) inh_left = $urandom_range(1, 5);
            r_inh = (inh_left > 0);
            step(r_rst, ($urandom_range(0, 9) < 7), rd, 1'($urandom), r_inh);
        end
        idle_until_empty();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
